// File: rtl/sgpr_wr_port_arbiter_if.sv
// Write-port bundle between SGPR write producers and the port arbiter.
//   port_wr_en/addr/data/mask : per-port write pulses, flat buses (port i at slice i)
//   port_busy                 : per-port pending buffer full
//   ovf_clear / port_ovf      : clear strobe and sticky per-port dropped-write flags
//   muxed_port_*              : registered single write into the SGPR bank
// Modports: master = producer side, slave = arbiter side.
interface sgpr_wr_port_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PTR_WIDTH  = 3
);
  logic [NUM_PORTS-1:0]            port_wr_en;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_wr_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_data;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_mask;
  logic [NUM_PORTS-1:0]            port_busy;
  logic                            ovf_clear;
  logic [NUM_PORTS-1:0]            port_ovf;
  logic                            muxed_port_wr_en;
  logic [ADDR_WIDTH-1:0]           muxed_port_wr_addr;
  logic [DATA_WIDTH-1:0]           muxed_port_wr_data;
  logic [DATA_WIDTH-1:0]           muxed_port_wr_mask;
  logic [PTR_WIDTH-1:0]            muxed_port_grant_id;

  modport master (
    output port_wr_en, port_wr_addr, port_wr_data, port_wr_mask, ovf_clear,
    input  port_busy, port_ovf, muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data,
    input  muxed_port_wr_mask, muxed_port_grant_id
  );

  modport slave (
    input  port_wr_en, port_wr_addr, port_wr_data, port_wr_mask, ovf_clear,
    output port_busy, port_ovf, muxed_port_wr_en, muxed_port_wr_addr, muxed_port_wr_data,
    output muxed_port_wr_mask, muxed_port_grant_id
  );
endinterface

// File: rtl/sgpr_wr_port_arbiter.sv
// N-port SGPR write arbiter: each port has a one-entry pending buffer, a round-robin
// arbiter picks one requester per cycle and the winner is registered onto the bank port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sgpr_wr_port_arbiter_if.slave (producer writes in, muxed write out,
//              per-port busy and sticky overflow flags)
module sgpr_wr_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input logic                    clk,
  input logic                    rst,
  sgpr_wr_port_arbiter_if.slave  bus
);

  logic [NUM_PORTS-1:0]  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] pend_addr_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pend_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pend_data_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pend_mask_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pend_mask_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  ovf_q, ovf_d;
  logic [PTR_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                  out_en_q, out_en_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] out_mask_q, out_mask_d;
  logic [PTR_WIDTH-1:0]  out_gid_q, out_gid_d;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  gnt_oh;
  logic [PTR_WIDTH-1:0]  gnt_idx;
  logic                  gnt_found;

  assign req = pend_valid_q | bus.port_wr_en;

  // Round-robin search: first pass covers ports at/above the pointer, second pass wraps
  // to the ports below it. Only reached when the first pass found nothing.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_found && req[i] && (PTR_WIDTH'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_WIDTH'(i);
        gnt_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_found && req[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_WIDTH'(i);
        gnt_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    // A drop in the same cycle as the clear still sets its flag.
    ovf_d        = bus.ovf_clear ? '0 : ovf_q;
    rr_ptr_d     = rr_ptr_q;
    out_en_d     = gnt_found;
    out_addr_d   = '0;
    out_data_d   = '0;
    out_mask_d   = '0;
    out_gid_d    = gnt_found ? gnt_idx : '0;

    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == PTR_WIDTH'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_oh[i]) begin
        // Older pending write leaves first; otherwise the incoming write bypasses.
        if (pend_valid_q[i]) begin
          out_addr_d = pend_addr_q[i];
          out_data_d = pend_data_q[i];
          out_mask_d = pend_mask_q[i];
        end else begin
          out_addr_d = bus.port_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          out_data_d = bus.port_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_mask_d = bus.port_wr_mask[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Buffer refills when it drained this cycle (granted) or was empty (not granted).
      if (bus.port_wr_en[i] && (gnt_oh[i] ? pend_valid_q[i] : !pend_valid_q[i])) begin
        pend_addr_d[i] = bus.port_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pend_data_d[i] = bus.port_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        pend_mask_d[i] = bus.port_wr_mask[i*DATA_WIDTH +: DATA_WIDTH];
      end

      if (gnt_oh[i]) begin
        pend_valid_d[i] = pend_valid_q[i] & bus.port_wr_en[i];
      end else if (bus.port_wr_en[i]) begin
        if (pend_valid_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= '0;
      ovf_q        <= '0;
      rr_ptr_q     <= '0;
      out_en_q     <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      out_gid_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
      rr_ptr_q     <= rr_ptr_d;
      out_en_q     <= out_en_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      out_gid_q    <= out_gid_d;
    end
  end

  // Buffer contents are qualified by pend_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
    pend_mask_q <= pend_mask_d;
  end

  assign bus.port_busy           = pend_valid_q;
  assign bus.port_ovf            = ovf_q;
  assign bus.muxed_port_wr_en    = out_en_q;
  assign bus.muxed_port_wr_addr  = out_addr_q;
  assign bus.muxed_port_wr_data  = out_data_q;
  assign bus.muxed_port_wr_mask  = out_mask_q;
  assign bus.muxed_port_grant_id = out_gid_q;

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
module tb_sgpr_wr_port_arbiter;
  localparam int N = 8;
  localparam int A = 9;
  localparam int D = 64;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sgpr_wr_port_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(A), .DATA_WIDTH(D), .PTR_WIDTH(P)) bus ();

  sgpr_wr_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(A), .DATA_WIDTH(D), .PTR_WIDTH(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-port one-deep FIFO, round-robin pointer as an integer.
  logic [N-1:0] m_pv;
  logic [A-1:0] m_addr [N];
  logic [D-1:0] m_data [N];
  logic [D-1:0] m_mask [N];
  logic [N-1:0] m_ovf;
  int           m_ptr;
  logic         x_en;
  logic [A-1:0] x_addr;
  logic [D-1:0] x_data;
  logic [D-1:0] x_mask;
  logic [P-1:0] x_gid;

  task automatic model_step();
    logic [N-1:0] en;
    logic [N-1:0] nov;
    int g;
    bit found;
    en = bus.port_wr_en;
    if (rst) begin
      m_pv = '0; m_ovf = '0; m_ptr = 0;
      x_en = 0; x_addr = '0; x_data = '0; x_mask = '0; x_gid = '0;
      return;
    end
    found = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!found && (m_pv[i] || en[i])) begin found = 1; g = i; end
    end
    nov = bus.ovf_clear ? '0 : m_ovf;
    x_en = 0; x_addr = '0; x_data = '0; x_mask = '0; x_gid = '0;
    if (found) begin
      x_en = 1; x_gid = P'(g);
      if (m_pv[g]) begin
        x_addr = m_addr[g]; x_data = m_data[g]; x_mask = m_mask[g];
        m_pv[g] = en[g];
        if (en[g]) begin
          m_addr[g] = bus.port_wr_addr[g*A +: A];
          m_data[g] = bus.port_wr_data[g*D +: D];
          m_mask[g] = bus.port_wr_mask[g*D +: D];
        end
      end else begin
        x_addr = bus.port_wr_addr[g*A +: A];
        x_data = bus.port_wr_data[g*D +: D];
        x_mask = bus.port_wr_mask[g*D +: D];
      end
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (!(found && i == g) && en[i]) begin
        if (m_pv[i]) nov[i] = 1'b1;
        else begin
          m_pv[i] = 1'b1;
          m_addr[i] = bus.port_wr_addr[i*A +: A];
          m_data[i] = bus.port_wr_data[i*D +: D];
          m_mask[i] = bus.port_wr_mask[i*D +: D];
        end
      end
    end
    m_ovf = nov;
  endtask

  task automatic idle();
    bus.port_wr_en = '0; bus.port_wr_addr = '0; bus.port_wr_data = '0;
    bus.port_wr_mask = '0; bus.ovf_clear = 1'b0;
  endtask

  task automatic put(input int p, input logic [A-1:0] a, input logic [D-1:0] d,
                     input logic [D-1:0] m);
    bus.port_wr_en[p] = 1'b1;
    bus.port_wr_addr[p*A +: A] = a;
    bus.port_wr_data[p*D +: D] = d;
    bus.port_wr_mask[p*D +: D] = m;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); put(2, 9'h011, 64'h1, 64'h1);
    tick(); tick();
    rst = 0; idle();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b0 || bus.muxed_port_wr_addr !== '0 ||
        bus.muxed_port_wr_data !== '0 || bus.muxed_port_wr_mask !== '0 ||
        bus.muxed_port_grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_out: en=%b addr=%h gid=%0d required all zero",
               bus.muxed_port_wr_en, bus.muxed_port_wr_addr, bus.muxed_port_grant_id);
    end
    n_checks++;
    if (bus.port_busy !== 8'h00 || bus.port_ovf !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%h ovf=%h required 00/00", bus.port_busy, bus.port_ovf);
    end
  endtask

  task automatic test_single();
    idle(); put(3, 9'h05A, 64'h1234, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b1 || bus.muxed_port_wr_addr !== 9'h05A ||
        bus.muxed_port_wr_data !== 64'h1234 || bus.muxed_port_wr_mask !== {D{1'b1}} ||
        bus.muxed_port_grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL single_out: en=%b addr=%h data=%h gid=%0d required 1/05a/1234/3",
               bus.muxed_port_wr_en, bus.muxed_port_wr_addr, bus.muxed_port_wr_data,
               bus.muxed_port_grant_id);
    end
    n_checks++;
    if (bus.port_busy !== 8'h00) begin
      n_fail++;
      $display("FAIL single_busy: busy=%h required 00", bus.port_busy);
    end
    tick();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b0 || bus.muxed_port_grant_id !== '0) begin
      n_fail++;
      $display("FAIL single_idle: en=%b gid=%0d required 0/0",
               bus.muxed_port_wr_en, bus.muxed_port_grant_id);
    end
    // Pointer now 4: ports 2 and 5 together must pick 5 first.
    put(2, 9'h002, 64'h22, '1); put(5, 9'h005, 64'h55, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd5) begin
      n_fail++;
      $display("FAIL single_ptr: gid=%0d required 5", bus.muxed_port_grant_id);
    end
    tick(); tick();
  endtask

  task automatic test_all_ports();
    logic [D-1:0] dd [N];
    logic [7:0] eb;
    rst = 1; idle(); tick(); rst = 0;
    for (int i = 0; i < N; i++) begin
      dd[i] = {$urandom, $urandom};
      put(i, A'(9'h100 + i), dd[i], '1);
    end
    tick(); idle();
    for (int c = 0; c < N; c++) begin
      eb = 8'hFF << (c + 1);
      n_checks++;
      if (bus.muxed_port_wr_en !== 1'b1 || bus.muxed_port_grant_id !== P'(c) ||
          bus.muxed_port_wr_addr !== A'(9'h100 + c) || bus.muxed_port_wr_data !== dd[c]) begin
        n_fail++;
        $display("FAIL all_ports_out[%0d]: en=%b gid=%0d addr=%h data=%h required gid=%0d data=%h",
                 c, bus.muxed_port_wr_en, bus.muxed_port_grant_id, bus.muxed_port_wr_addr,
                 bus.muxed_port_wr_data, c, dd[c]);
      end
      n_checks++;
      if (bus.port_busy !== eb || bus.port_ovf !== 8'h00) begin
        n_fail++;
        $display("FAIL all_ports_busy[%0d]: busy=%h ovf=%h required %h/00",
                 c, bus.port_busy, bus.port_ovf, eb);
      end
      tick();
    end
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL all_ports_done: en=%b required 0", bus.muxed_port_wr_en);
    end
  endtask

  task automatic test_wrap();
    rst = 1; idle(); tick(); rst = 0;
    put(5, 9'h005, 64'h5, '1); tick(); idle(); tick();
    put(1, 9'h0A1, 64'hA1, '1); put(7, 9'h0A7, 64'hA7, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd7 || bus.muxed_port_wr_addr !== 9'h0A7 ||
        bus.port_busy !== 8'h02) begin
      n_fail++;
      $display("FAIL wrap_first: gid=%0d addr=%h busy=%h required 7/0a7/02",
               bus.muxed_port_grant_id, bus.muxed_port_wr_addr, bus.port_busy);
    end
    tick();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd1 || bus.muxed_port_wr_data !== 64'hA1 ||
        bus.port_busy !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_second: gid=%0d data=%h busy=%h required 1/a1/00",
               bus.muxed_port_grant_id, bus.muxed_port_wr_data, bus.port_busy);
    end
    put(1, 9'h0B1, 64'hB1, '1); put(2, 9'h0B2, 64'hB2, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd2) begin
      n_fail++;
      $display("FAIL wrap_ptr: gid=%0d required 2", bus.muxed_port_grant_id);
    end
    tick(); tick();
  endtask

  task automatic test_overflow();
    rst = 1; idle(); tick(); rst = 0;
    put(0, 9'h010, 64'hA0, '1); put(1, 9'h011, 64'hA1, '1);
    tick(); idle();
    put(1, 9'h021, 64'hB1, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd1 || bus.muxed_port_wr_data !== 64'hA1 ||
        bus.port_busy !== 8'h02) begin
      n_fail++;
      $display("FAIL ovf_refill_a: gid=%0d data=%h busy=%h required 1/a1/02",
               bus.muxed_port_grant_id, bus.muxed_port_wr_data, bus.port_busy);
    end
    tick();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd1 || bus.muxed_port_wr_data !== 64'hB1 ||
        bus.port_ovf !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_refill_b: gid=%0d data=%h ovf=%h required 1/b1/00",
               bus.muxed_port_grant_id, bus.muxed_port_wr_data, bus.port_ovf);
    end
    put(2, 9'h032, 64'hC2, '1); put(1, 9'h031, 64'hC1, '1);
    tick(); idle();
    put(1, 9'h041, 64'hD1, '1); put(3, 9'h043, 64'hD3, '1);
    tick(); idle();
    n_checks++;
    if (bus.port_ovf !== 8'h02 || bus.muxed_port_grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL ovf_drop: ovf=%h gid=%0d required 02/3", bus.port_ovf,
               bus.muxed_port_grant_id);
    end
    tick();
    n_checks++;
    if (bus.muxed_port_grant_id !== 3'd1 || bus.muxed_port_wr_data !== 64'hC1) begin
      n_fail++;
      $display("FAIL ovf_kept: gid=%0d data=%h required 1/c1",
               bus.muxed_port_grant_id, bus.muxed_port_wr_data);
    end
    tick();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b0 || bus.port_ovf !== 8'h02) begin
      n_fail++;
      $display("FAIL ovf_dropped_gone: en=%b ovf=%h required 0/02",
               bus.muxed_port_wr_en, bus.port_ovf);
    end
  endtask

  task automatic test_ovf_clear();
    put(2, 9'h050, 64'hE2, '1); tick(); idle(); tick();
    put(3, 9'h053, 64'hE3, '1); put(2, 9'h052, 64'hF2, '1);
    tick(); idle();
    put(4, 9'h054, 64'hE4, '1); put(2, 9'h062, 64'h12, '1); bus.ovf_clear = 1'b1;
    tick(); idle();
    n_checks++;
    if (bus.port_ovf !== 8'h04) begin
      n_fail++;
      $display("FAIL ovf_clear_collision: ovf=%h required 04", bus.port_ovf);
    end
    tick(); tick();
    n_checks++;
    if (bus.port_busy !== 8'h00 || bus.port_ovf !== 8'h04) begin
      n_fail++;
      $display("FAIL ovf_clear_drain: busy=%h ovf=%h required 00/04",
               bus.port_busy, bus.port_ovf);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) put(i, A'(9'h070 + i), 64'(i), '1);
    tick(); idle();
    n_checks++;
    if ($countones(bus.port_busy) != 5) begin
      n_fail++;
      $display("FAIL mid_pending: busy=%h required five bits set", bus.port_busy);
    end
    rst = 1; put(6, 9'h076, 64'h6, '1);
    tick(); rst = 0; idle();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b0 || bus.port_busy !== 8'h00 || bus.port_ovf !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: en=%b busy=%h ovf=%h required 0/00/00",
               bus.muxed_port_wr_en, bus.port_busy, bus.port_ovf);
    end
    put(5, 9'h155, 64'h55AA, '1);
    tick(); idle();
    n_checks++;
    if (bus.muxed_port_wr_en !== 1'b1 || bus.muxed_port_grant_id !== 3'd5 ||
        bus.muxed_port_wr_addr !== 9'h155) begin
      n_fail++;
      $display("FAIL mid_after: en=%b gid=%0d addr=%h required 1/5/155",
               bus.muxed_port_wr_en, bus.muxed_port_grant_id, bus.muxed_port_wr_addr);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      bus.ovf_clear = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        // Mostly well-behaved producers; occasional busy violations exercise overflow.
        if ($urandom_range(0, 99) < 35 && (!m_pv[i] || $urandom_range(0, 9) == 0))
          put(i, A'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      end
      tick();
      n_checks++;
      if (bus.muxed_port_wr_en !== x_en || bus.muxed_port_grant_id !== x_gid ||
          bus.muxed_port_wr_addr !== x_addr || bus.muxed_port_wr_data !== x_data ||
          bus.muxed_port_wr_mask !== x_mask) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: en=%b gid=%0d addr=%h data=%h required en=%b gid=%0d addr=%h data=%h",
                 c, bus.muxed_port_wr_en, bus.muxed_port_grant_id, bus.muxed_port_wr_addr,
                 bus.muxed_port_wr_data, x_en, x_gid, x_addr, x_data);
      end
      n_checks++;
      if (bus.port_busy !== m_pv || bus.port_ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: busy=%h ovf=%h required %h/%h",
                 c, bus.port_busy, bus.port_ovf, m_pv, m_ovf);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    m_pv = '0; m_ovf = '0; m_ptr = 0;
    x_en = 0; x_addr = '0; x_data = '0; x_mask = '0; x_gid = '0;
    test_reset();
    test_single();
    test_all_ports();
    test_wrap();
    test_overflow();
    test_ovf_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
